// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding,
// the captured debug request bundle and default parameter values.
package dmem_arb_pkg;

    // Default widths; the captured-request struct is sized from these,
    // so the arbiter's DM_ADDRESS/DATA_W must match them.
    localparam int DM_ADDRESS_DEF = 9;
    localparam int DATA_W_DEF     = 32;
    localparam int MAX_WAIT_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                      we;
        logic [DM_ADDRESS_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [2:0]                func3;
    } dbg_req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Ports: clk, reset (sync, active-low), inc (count enable), q (count).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and a
// debug/loader port, with a bounded wait before forcing a debug grant.
// Ports: clk, reset (sync, active-low); cpu_* MEM-stage access, cpu_rdata,
// cpu_stall, cpu_halted; dbg_* request/ack/rdata; mem_* to datamemory;
// forced_cnt = saturating count of forced grants.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDRESS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_func3,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  cpu_halted,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_ack,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [CNT_W-1:0]      forced_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_t state;
    dbg_req_t   req_q;
    logic [7:0] wait_cnt;
    logic       forced;
    logic       cpu_acc;
    logic       grant;

    assign cpu_acc = cpu_rd | cpu_wr;
    assign grant   = (state == GRANT);

    // Both handshake outputs come straight from the state register.
    assign cpu_stall = grant;
    assign dbg_ack   = (state == RESP);
    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            req_q     <= '0;
            wait_cnt  <= '0;
            forced    <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dbg_req) begin
                        req_q.we    <= dbg_we;
                        req_q.addr  <= dbg_addr;
                        req_q.wdata <= dbg_wdata;
                        req_q.func3 <= dbg_func3;
                        wait_cnt    <= '0;
                        forced      <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // Halt outranks the timeout check.
                    if (!cpu_acc || cpu_halted) begin
                        forced <= 1'b0;
                        state  <= GRANT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        forced <= 1'b1;
                        state  <= GRANT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                GRANT: begin
                    if (!req_q.we) begin
                        dbg_rdata <= mem_rdata;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_forced_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (grant & forced),
        .q    (forced_cnt)
    );

    // The port belongs to the CPU except in GRANT; enables are
    // suppressed while reset is held.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_func3 = cpu_func3;
        if (grant) begin
            mem_rd    = reset & ~req_q.we;
            mem_wr    = reset & req_q.we;
            mem_addr  = req_q.addr;
            mem_wdata = req_q.wdata;
            mem_func3 = req_q.func3;
        end else begin
            mem_rd = reset & cpu_rd;
            mem_wr = reset & cpu_wr;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the pipeline MEM stage and a debug/loader port. It sits between the EX/MEM register outputs and `datamemory`. The CPU has priority. A debug request waits for an idle CPU cycle, or for the halt flag. A wait counter bounds debug starvation: on timeout, the arbiter takes the port for one cycle and stalls the pipeline.

## Interface
Parameters:
- `DM_ADDRESS`, 9: data-memory byte address width
- `DATA_W`, 32: data width
- `MAX_WAIT`, 8: cycles a pending debug request may wait before it is forced; legal range 1..255
- `CNT_W`, 16: width of the forced-grant statistics counter

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-low; state clears on a rising edge where `reset`=0
- `cpu_rd`, `cpu_wr`  in  1 each  MEM-stage read/write enables
- `cpu_addr`  in  DM_ADDRESS  MEM-stage address
- `cpu_wdata`  in  DATA_W  MEM-stage store data
- `cpu_func3`  in  3  access size/sign
- `cpu_rdata`  out  DATA_W  load data to the MEM/WB register
- `cpu_stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM for this cycle
- `cpu_halted`  in  1  high while the pipeline is halted
- `dbg_req`  in  1  debug request, level-sensitive
- `dbg_we`  in  1  debug request is a write (1) or a read (0)
- `dbg_addr`  in  DM_ADDRESS  debug address
- `dbg_wdata`  in  DATA_W  debug write data
- `dbg_func3`  in  3  debug access size
- `dbg_ack`  out  1  one-cycle pulse: debug access complete
- `dbg_rdata`  out  DATA_W  read result; valid with `dbg_ack` and held until the next grant
- `mem_rd`, `mem_wr`  out  1 each  to `datamemory`
- `mem_addr`  out  DM_ADDRESS  to `datamemory`
- `mem_wdata`  out  DATA_W  to `datamemory`
- `mem_func3`  out  3  to `datamemory`
- `mem_rdata`  in  DATA_W  from `datamemory`; same-cycle (combinational) data
- `forced_cnt`  out  CNT_W  number of forced grants, saturating

## Operation
FSM states: IDLE, WAIT, GRANT, RESP.
- **IDLE**
  - `dbg_req`=1: capture `dbg_we`, `dbg_addr`, `dbg_wdata` and `dbg_func3` into request registers; clear `wait_cnt`; go to WAIT.
- **WAIT**
  - Let `cpu_acc` = `cpu_rd` | `cpu_wr`.
  - If `cpu_acc`=0 or `cpu_halted`=1: go to GRANT with forced=0.
  - Else if `wait_cnt`=MAX_WAIT-1: go to GRANT with forced=1.
  - Else: increment `wait_cnt`.
  - Live `dbg_*` inputs are ignored here; the captured copy is used.
- **GRANT**
  - Mem port is driven from the captured request; `cpu_stall`=1.
  - Read: `dbg_rdata` <= `mem_rdata`.
  - If forced=1: `forced_cnt` += 1, saturating at all-ones.
  - Next state: RESP.
- **RESP**
  - `dbg_ack`=1; next state: IDLE.
- **Mem port muxing**
  - In every state except GRANT, the `mem_*` outputs pass through the `cpu_*` inputs.
  - `cpu_rdata` = `mem_rdata` always; the CPU ignores it while stalled.
- **Debug handshake**
  - Hold the request fields stable while `dbg_req`=1 until WAIT is entered. Since they are captured, they may change afterwards.
  - `dbg_req` sampled high in IDLE is always a new request. To issue exactly one access, the requester drops `dbg_req` in the cycle after `dbg_ack`. Holding it high issues back-to-back requests.
- `cpu_stall` and `dbg_ack` are decoded from the state register only. There is no combinational path from the `cpu_*` or `dbg_*` inputs to either.

## Timing
- **Reset values** (`reset`=0 at an edge):
  - state = IDLE, `wait_cnt`=0, `forced_cnt`=0, `dbg_rdata`=0
  - `dbg_ack`=0, `cpu_stall`=0
  - While `reset`=0, `mem_rd`=`mem_wr`=0 regardless of the CPU inputs.
- **Reset mid-operation:** the captured request is discarded and no `dbg_ack` is issued. The requester must re-issue.
- **Debug latency:**
  - Best case, CPU idle: `dbg_req` is sampled at edge 0; WAIT in cycle 1, GRANT in cycle 2, `dbg_ack` in cycle 3.
  - Worst case: GRANT in cycle MAX_WAIT+1 and `dbg_ack` in cycle MAX_WAIT+2.
- **CPU impact:** `cpu_stall` is at most one cycle per debug request. The stalled CPU access is not performed in that cycle; the frozen EX/MEM register re-presents it in the next cycle.
- **Simultaneous events:** a natural GRANT (forced=0) still asserts `cpu_stall`; it costs nothing because the CPU issued no access that cycle. `cpu_halted` takes priority over the timeout check.
- A debug write and a CPU access never reach memory in the same cycle.

## Structure
- Package `dmem_arb_pkg`:
  - typedef enum `arb_state_t` {IDLE, WAIT, GRANT, RESP}
  - struct `dbg_req_t` {we, addr, wdata, func3} for the captured request
  - default `MAX_WAIT`
- One sub-module, `sat_counter`, with parameters `W`, inputs `clk`, `reset` and `inc`, and output `q`. Used for `forced_cnt`.
- The FSM, request registers and mux live in `dmem_arbiter`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `cpu_wr`=1. Required: `mem_wr`=0, `dbg_ack`=0, `forced_cnt`=0, `cpu_stall`=0.
- **Idle CPU debug read:** memory word 0x40 = 0xDEADBEEF; `dbg_req` with `dbg_we`=0 and `dbg_addr`=0x40; CPU idle. Required: `cpu_stall` in cycle 2 only; `dbg_ack` in cycle 3 with `dbg_rdata`=0xDEADBEEF; `forced_cnt`=0.
- **Forced grant:** CPU issues a load every cycle; MAX_WAIT=8; debug write of 0x12345678 to 0x10. Required: GRANT in cycle 9 with `cpu_stall` for exactly one cycle; `dbg_ack` in cycle 10; `forced_cnt`=1. Afterwards, a CPU load from 0x10 returns 0x12345678, and the stalled CPU load completes in cycle 10 with correct data.
- **Halted CPU:** `cpu_halted`=1 and `cpu_rd`=1 held; debug request issued. Required: GRANT in cycle 2; `forced_cnt` unchanged.
- **Reset mid-operation:** assert `reset` while in WAIT. Required: state returns to IDLE, no `dbg_ack` pulse, `mem_*` follows the CPU after release.
- **Back-to-back:** `dbg_req` held high for two requests. Required: two `dbg_ack` pulses 4 cycles apart, and the `forced_cnt` saturation path is exercised with CNT_W=2 after 4 forced grants (value stays 3).
